// File: rtl/reaction_timer_ctrl.sv
// Reaction-timer game sequencer. After a start press it waits a pseudo-random
// number of ticks, then lights the stimulus LED and counts the reaction time
// in ticks as two BCD digits. The result is shown on the x/y/readit interface
// of the display latch. False starts and timeouts are also reported.
module reaction_timer_ctrl #(
  parameter int TICK_DIV  = 500000,
  parameter int MIN_WAIT  = 100,
  parameter int RAND_BITS = 8
) (
  input  logic       clk50M,
  input  logic       reset_n,
  input  logic       start_btn,
  input  logic       react_btn,
  output logic       stim_led,
  output logic [3:0] x,
  output logic [3:0] y,
  output logic       readit,
  output logic       busy,
  output logic       foul,
  output logic       timeout
);

  localparam int PRESC_W = $clog2(TICK_DIV);
  localparam int WAIT_W  = $clog2(MIN_WAIT + 2**RAND_BITS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_STIM,
    ST_RESULT,
    ST_FOUL
  } state_t;

  state_t             state, state_nxt;
  logic [PRESC_W-1:0] presc, presc_nxt;
  logic [WAIT_W-1:0]  wait_cnt, wait_nxt;
  logic [3:0]         ones, ones_nxt;
  logic [3:0]         tens, tens_nxt;
  logic               to_flag, to_nxt;
  logic [15:0]        lfsr;
  logic               start_prev, react_prev;
  logic               start_rise, react_rise;
  logic               tick;

  assign start_rise = start_btn & ~start_prev;
  assign react_rise = react_btn & ~react_prev;
  assign tick       = (presc == PRESC_W'(TICK_DIV - 1));
  assign busy       = (state != ST_IDLE);

  // Button history for edge detection and the free-running delay LFSR.
  always_ff @(posedge clk50M or negedge reset_n) begin
    if (!reset_n) begin
      start_prev <= 1'b0;
      react_prev <= 1'b0;
      lfsr       <= 16'hACE1;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge value of the others, so update order inside the block is irrelevant.
      start_prev <= start_btn;
      react_prev <= react_btn;
      lfsr       <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  // Sequencer state, tick prescaler, delay counter and BCD digits.
  always_ff @(posedge clk50M or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      presc    <= '0;
      wait_cnt <= '0;
      ones     <= '0;
      tens     <= '0;
      to_flag  <= 1'b0;
    end else begin
      state    <= state_nxt;
      presc    <= presc_nxt;
      wait_cnt <= wait_nxt;
      ones     <= ones_nxt;
      tens     <= tens_nxt;
      to_flag  <= to_nxt;
    end
  end

  // Next-state logic; button events win over a tick in the same cycle.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_nxt = state;
    wait_nxt  = wait_cnt;
    ones_nxt  = ones;
    tens_nxt  = tens;
    to_nxt    = to_flag;
    unique case (state)
      ST_IDLE: begin
        if (start_rise) begin
          state_nxt = ST_WAIT;
          wait_nxt  = WAIT_W'(MIN_WAIT) + WAIT_W'(lfsr[RAND_BITS-1:0]);
          to_nxt    = 1'b0;
        end
      end
      ST_WAIT: begin
        if (react_rise) begin
          state_nxt = ST_FOUL;
        end else if (tick) begin
          if (wait_cnt == WAIT_W'(1)) begin
            state_nxt = ST_STIM;
            ones_nxt  = 4'd0;
            tens_nxt  = 4'd0;
          end else begin
            wait_nxt = wait_cnt - 1'b1;
          end
        end
      end
      ST_STIM: begin
        if (react_rise) begin
          state_nxt = ST_RESULT;
        end else if (tick) begin
          if (ones == 4'd9 && tens == 4'd9) begin
            state_nxt = ST_RESULT;
            to_nxt    = 1'b1;
          end else if (ones == 4'd9) begin
            ones_nxt = 4'd0;
            tens_nxt = tens + 4'd1;
          end else begin
            ones_nxt = ones + 4'd1;
          end
        end
      end
      ST_RESULT, ST_FOUL: begin
        if (start_rise) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Restarting the prescaler on entry gives a full tick period in each state.
    if (state_nxt != state || tick) presc_nxt = '0;
    else                            presc_nxt = presc + 1'b1;
  end

  // Registered Moore outputs decoded from the current state.
  always_ff @(posedge clk50M or negedge reset_n) begin
    if (!reset_n) begin
      stim_led <= 1'b0;
      readit   <= 1'b0;
      foul     <= 1'b0;
      timeout  <= 1'b0;
      x        <= 4'd0;
      y        <= 4'd0;
    end else begin
      stim_led <= (state == ST_STIM);
      readit   <= (state == ST_RESULT) || (state == ST_FOUL);
      foul     <= (state == ST_FOUL);
      timeout  <= (state == ST_RESULT) && to_flag;
      unique case (state)
        ST_STIM, ST_RESULT: begin
          x <= ones;
          y <= tens;
        end
        ST_FOUL: begin
          x <= 4'hF;
          y <= 4'hF;
        end
        default: begin
          x <= 4'd0;
          y <= 4'd0;
        end
      endcase
    end
  end

endmodule
